// File: rtl/box_track_pkg.sv
// box_track_pkg: state encoding, LFSR taps and saturating add
// shared by the platform scroller (see BOX_RANDOM_GAP_EN in top).
package box_track_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCROLL,
    SHIFT,
    DONE
  } state_t;

  // Fibonacci taps 16,14,13,11 as bit mask
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [31:0] sat_add(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] lim
  );
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, lim}) ? lim : s[31:0];
  endfunction

  function automatic logic [15:0] lfsr_next(
    input logic [15:0] s
  );
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/box_lfsr16.sv
// box_lfsr16: free-running 16-bit Fibonacci LFSR used for
// random platform gaps (only built with BOX_RANDOM_GAP_EN).
module box_lfsr16
  import box_track_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED;
    end else if (en) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/box_track_scroller.sv
// box_track_scroller: scrolls N platforms left on reload, then
// shifts the list and spawns a tail. Macro: BOX_RANDOM_GAP_EN.
module box_track_scroller
  import box_track_pkg::*;
#(
  parameter int          N_BLOCKS      = 4,
  parameter int          X_W           = 10,
  parameter int          CNT_W         = 17,
  parameter int          HOME_X        = 80,
  parameter int          SCREEN_W      = 640,
  parameter int          GAP_MIN       = 120,
  parameter int          GAP_RAND_BITS = 6,
  parameter int          STEP          = 4,
  parameter int          TICK_DIV      = 2,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                    clk_machine,
  input  logic                    rst_machine,
  input  logic                    i_reload,
  output logic [N_BLOCKS*X_W-1:0] o_x_block,
  output logic [N_BLOCKS-1:0]     o_en_block,
  output logic                    o_busy,
  output logic                    reload_done,
  output logic [CNT_W-1:0]        cnt_clk_reload
);

  localparam logic [31:0] XMAX =
    32'((64'd1 << X_W) - 64'd1);
  localparam int TW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_t         state;
  logic [X_W-1:0] x [N_BLOCKS];
  logic [X_W-1:0] rem;
  logic [X_W-1:0] d;
  logic [X_W-1:0] tail;
  logic [TW-1:0]  tick_cnt;
  logic [31:0]    gap;
  logic           tick;
  logic           ahead;

  function automatic logic vis(
    input logic [X_W-1:0] v
  );
    return 32'(v) < 32'(SCREEN_W);
  endfunction

  function automatic logic [X_W-1:0] start_x(
    input int i
  );
    return X_W'(sat_add(32'(HOME_X),
                        32'(i * GAP_MIN), XMAX));
  endfunction

`ifdef BOX_RANDOM_GAP_EN
  logic [15:0] lfsr;
  logic        lfsr_unused;

  box_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk_machine),
    .rst   (rst_machine),
    .en    (1'b1),
    .state (lfsr)
  );

  assign gap = 32'(GAP_MIN)
             + 32'(lfsr[GAP_RAND_BITS-1:0]);
  assign lfsr_unused = ^lfsr;
`else
  localparam int cfg_unused =
    GAP_RAND_BITS + int'(LFSR_SEED);
  assign gap = 32'(GAP_MIN);
`endif

  assign tick  = (tick_cnt == TW'(TICK_DIV - 1));
  assign d     = (rem < X_W'(STEP)) ? rem : X_W'(STEP);
  assign ahead = 32'(x[1]) > 32'(HOME_X);
  assign tail  = X_W'(sat_add(32'(x[N_BLOCKS-1]),
                              gap, XMAX));

  always_ff @(posedge clk_machine) begin
    if (rst_machine) begin
      state          <= IDLE;
      rem            <= '0;
      tick_cnt       <= '0;
      o_busy         <= 1'b0;
      reload_done    <= 1'b0;
      cnt_clk_reload <= '0;
      for (int i = 0; i < N_BLOCKS; i++) begin
        x[i]          <= start_x(i);
        o_en_block[i] <= vis(start_x(i));
      end
    end else begin
      reload_done <= 1'b0;
      if (o_busy && !(&cnt_clk_reload)) begin
        cnt_clk_reload <= cnt_clk_reload + CNT_W'(1);
      end
      unique case (state)
        IDLE: begin
          if (i_reload) begin
            rem <= ahead
                 ? X_W'(32'(x[1]) - 32'(HOME_X))
                 : '0;
            cnt_clk_reload <= '0;
            tick_cnt       <= '0;
            o_busy         <= 1'b1;
            state          <= ahead ? SCROLL : SHIFT;
          end
        end
        SCROLL: begin
          if (tick) begin
            tick_cnt <= '0;
            rem      <= rem - d;
            if (rem == d) state <= SHIFT;
            // blocks pushed past the left edge park at 0, hidden
            for (int i = 0; i < N_BLOCKS; i++) begin
              if (x[i] < d) begin
                x[i]          <= '0;
                o_en_block[i] <= 1'b0;
              end else begin
                x[i]          <= x[i] - d;
                o_en_block[i] <= vis(x[i] - d);
              end
            end
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        SHIFT: begin
          for (int i = 0; i < N_BLOCKS - 1; i++) begin
            x[i]          <= x[i+1];
            o_en_block[i] <= o_en_block[i+1];
          end
          x[N_BLOCKS-1]          <= tail;
          o_en_block[N_BLOCKS-1] <= vis(tail);
          state                  <= DONE;
        end
        DONE: begin
          reload_done <= 1'b1;
          o_busy      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  for (genvar g = 0; g < N_BLOCKS; g++) begin : g_out
    assign o_x_block[g*X_W +: X_W] = x[g];
  end

endmodule

// File: tb/tb_box_track_scroller.sv
// tb_box_track_scroller: scoreboard bench, two instances
// (default gap and wide gap 350); honours BOX_RANDOM_GAP_EN.
module tb_box_track_scroller;

  localparam int HOME  = 80;
  localparam int SCR   = 640;
  localparam int STEPP = 4;
  localparam int TDIV  = 2;
  localparam int XMAXV = 1023;
  localparam int GAP_A = 120;
  localparam int GAP_B = 350;

  typedef struct packed {
    logic [39:0] x;
    logic [3:0]  en;
    logic [15:0] lat;
  } exp_t;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic reload = 1'b0;
  logic sel = 1'b0;
  logic reload_a, reload_b;
  assign reload_a = reload & ~sel;
  assign reload_b = reload & sel;

  logic [39:0] x_a, x_b;
  logic [3:0]  en_a, en_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [16:0] cnt_a, cnt_b;

  box_track_scroller u_a (
    .clk_machine    (clk),
    .rst_machine    (rst_a),
    .i_reload       (reload_a),
    .o_x_block      (x_a),
    .o_en_block     (en_a),
    .o_busy         (busy_a),
    .reload_done    (done_a),
    .cnt_clk_reload (cnt_a)
  );

  box_track_scroller #(
    .GAP_MIN (GAP_B)
  ) u_b (
    .clk_machine    (clk),
    .rst_machine    (rst_b),
    .i_reload       (reload_b),
    .o_x_block      (x_b),
    .o_en_block     (en_b),
    .o_busy         (busy_b),
    .reload_done    (done_b),
    .cnt_clk_reload (cnt_b)
  );

  logic [39:0] v_x;
  logic [3:0]  v_en;
  logic        v_busy, v_done;
  logic [16:0] v_cnt;
  always_comb begin
    v_x    = sel ? x_b : x_a;
    v_en   = sel ? en_b : en_a;
    v_busy = sel ? busy_b : busy_a;
    v_done = sel ? done_b : done_a;
    v_cnt  = sel ? cnt_b : cnt_a;
  end

  int   n_cmp = 0;
  int   n_bad = 0;
  int   mx [2][4];
  logic [3:0] men [2];
  exp_t sb [$];

`ifdef BOX_RANDOM_GAP_EN
  logic [15:0] mlfsr [2];
  function automatic logic [15:0] lstep(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction
  always @(posedge clk) begin
    mlfsr[0] <= rst_a ? 16'hACE1 : lstep(mlfsr[0]);
    mlfsr[1] <= rst_b ? 16'hACE1 : lstep(mlfsr[1]);
  end
`endif

  function automatic int gapmin(input int s);
    return (s != 0) ? GAP_B : GAP_A;
  endfunction

  function automatic logic [39:0] pack_x(input int s);
    logic [39:0] p;
    for (int i = 0; i < 4; i++) p[i*10 +: 10] = 10'(mx[s][i]);
    return p;
  endfunction

  task automatic model_reset(input int s);
    int v;
    for (int i = 0; i < 4; i++) begin
      v = HOME + i * gapmin(s);
      if (v > XMAXV) v = XMAXV;
      mx[s][i] = v;
      men[s][i] = (v < SCR);
    end
  endtask

  // called on the negedge just before the accepting edge
  task automatic predict_push(input int s);
    int rem, ticks, g, t;
    int post [4];
    logic [3:0] pen;
    exp_t e;
    rem = (mx[s][1] > HOME) ? mx[s][1] - HOME : 0;
    ticks = (rem + STEPP - 1) / STEPP;
    e.lat = 16'(ticks * TDIV + 2);
    g = gapmin(s);
`ifdef BOX_RANDOM_GAP_EN
    begin
      logic [15:0] l;
      l = mlfsr[s];
      for (int k = 0; k < int'(e.lat) - 1; k++) l = lstep(l);
      g = g + int'(l[5:0]);
    end
`endif
    for (int i = 0; i < 4; i++) begin
      if (rem == 0) begin
        post[i] = mx[s][i];
        pen[i] = men[s][i];
      end else if (mx[s][i] >= rem) begin
        post[i] = mx[s][i] - rem;
        pen[i] = (post[i] < SCR);
      end else begin
        post[i] = 0;
        pen[i] = 1'b0;
      end
    end
    for (int i = 0; i < 3; i++) begin
      mx[s][i] = post[i+1];
      men[s][i] = pen[i+1];
    end
    t = post[3] + g;
    if (t > XMAXV) t = XMAXV;
    mx[s][3] = t;
    men[s][3] = (t < SCR);
    e.x = pack_x(s);
    e.en = men[s];
    sb.push_back(e);
  endtask

  // entered on the negedge right after the accepting edge
  task automatic wait_done(input bit tick_chk, output int k_done);
    exp_t e;
    k_done = -1;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      if (tick_chk && (k == 40 || k == 42)) begin
        n_cmp++;
        if (v_en[0] !== (k == 40)) begin
          n_bad++;
          $display("FAIL en0_tick k=%0d got %b want %b",
                   k, v_en[0], (k == 40));
        end
      end
      if (v_done === 1'b1) begin
        k_done = k;
        break;
      end
    end
    n_cmp++;
    if (k_done < 0) begin
      n_bad++;
      $display("FAIL done_timeout got none want pulse");
    end else if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL sb_empty got done want none");
    end else begin
      e = sb.pop_front();
      if (k_done != int'(e.lat)) begin
        n_bad++;
        $display("FAIL latency got %0d want %0d", k_done, e.lat);
      end
      n_cmp++;
      if (v_x !== e.x || v_en !== e.en) begin
        n_bad++;
        $display("FAIL positions got %h/%b want %h/%b",
                 v_x, v_en, e.x, e.en);
      end
      n_cmp++;
      if (v_cnt !== 17'(e.lat) || v_busy !== 1'b0) begin
        n_bad++;
        $display("FAIL cnt_busy got %0d/%b want %0d/0",
                 v_cnt, v_busy, e.lat);
      end
    end
  endtask

  task automatic run_reload(input bit tick_chk);
    int k;
    @(negedge clk);
    predict_push(sel ? 1 : 0);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    n_cmp++;
    if (v_busy !== 1'b1 || v_cnt !== 17'd0) begin
      n_bad++;
      $display("FAIL accept got busy=%b cnt=%0d want 1/0",
               v_busy, v_cnt);
    end
    wait_done(tick_chk, k);
    @(negedge clk);
    n_cmp++;
    if (v_done !== 1'b0) begin
      n_bad++;
      $display("FAIL done_pulse got %b want 0", v_done);
    end
  endtask

  task automatic test_reset;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    model_reset(0);
    model_reset(1);
    n_cmp++;
    if (x_a !== {10'd440, 10'd320, 10'd200, 10'd80}) begin
      n_bad++;
      $display("FAIL reset_x got %h want 80,200,320,440", x_a);
    end
    n_cmp++;
    if (en_a !== 4'b1111 || busy_a !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_en got %b/%b want 1111/0",
               en_a, busy_a);
    end
    n_cmp++;
    if (cnt_a !== 17'd0 || done_a !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_cnt got %0d/%b want 0/0",
               cnt_a, done_a);
    end
    n_cmp++;
    if (x_b !== {10'd1023, 10'd780, 10'd430, 10'd80}
        || en_b !== 4'b0011) begin
      n_bad++;
      $display("FAIL reset_b got %h/%b want sat/0011",
               x_b, en_b);
    end
  endtask

  task automatic test_reload;
    sel = 1'b0;
    run_reload(1'b1);
`ifndef BOX_RANDOM_GAP_EN
    n_cmp++;
    if (x_a !== {10'd440, 10'd320, 10'd200, 10'd80}
        || cnt_a !== 17'd62) begin
      n_bad++;
      $display("FAIL reload_fixed got %h/%0d want home/62",
               x_a, cnt_a);
    end
`endif
    run_reload(1'b0);
  endtask

  task automatic test_back_to_back;
    int k;
    sel = 1'b0;
    @(negedge clk);
    predict_push(0);
    reload = 1'b1;
    @(negedge clk);
    wait_done(1'b0, k);
    predict_push(0);
    n_cmp++;
    if (busy_a !== 1'b0) begin
      n_bad++;
      $display("FAIL held_idle got busy=%b want 0", busy_a);
    end
    @(negedge clk);
    reload = 1'b0;
    n_cmp++;
    if (busy_a !== 1'b1 || cnt_a !== 17'd0
        || done_a !== 1'b0) begin
      n_bad++;
      $display("FAIL held_second got %b/%0d/%b want 1/0/0",
               busy_a, cnt_a, done_a);
    end
    wait_done(1'b0, k);
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    int dones;
    sel = 1'b0;
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    repeat (30) @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    model_reset(0);
    n_cmp++;
    if (x_a !== pack_x(0) || en_a !== men[0]
        || busy_a !== 1'b0 || cnt_a !== 17'd0) begin
      n_bad++;
      $display("FAIL abort_state got %h/%b/%b/%0d want reset",
               x_a, en_a, busy_a, cnt_a);
    end
    dones = 0;
    for (int k = 0; k < 100; k++) begin
      if (done_a === 1'b1) dones++;
      @(negedge clk);
    end
    n_cmp++;
    if (dones != 0) begin
      n_bad++;
      $display("FAIL abort_done got %0d want 0", dones);
    end
  endtask

  task automatic test_saturate;
    sel = 1'b1;
    for (int r = 0; r < 3; r++) begin
      run_reload(1'b0);
      n_cmp++;
      if (x_b[9:0] !== 10'd80 || x_b[39:30] !== 10'd1023
          || en_b[3] !== 1'b0) begin
        n_bad++;
        $display("FAIL wide_gap r=%0d got %h/%b want 80..1023",
                 r, x_b, en_b);
      end
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reload();
    test_back_to_back();
    test_reset_abort();
    test_reload();
    test_saturate();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_leftover got %0d want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
